// File: rtl/fp_align_stage.sv
// Alignment front end of the single-precision FP add/sub: unpack, magnitude compare, sticky shift.
// Optional macro FP_ALIGN_DENORM_EN treats exponent-0 operands as subnormal instead of zero.
module fp_align_stage #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned GRS_W = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [EXP_W+MAN_W:0]     op1,
   input  logic [EXP_W+MAN_W:0]     op2,
   input  logic                     opcode_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     swap,
   output logic                     sign1_out,
   output logic                     sign2_out,
   output logic                     opcode_out,
   output logic [EXP_W-1:0]         exp_large,
   output logic [MAN_W+GRS_W:0]     mant_large,
   output logic [MAN_W+GRS_W:0]     mant_small
);

   localparam int unsigned SIG_W = MAN_W + 1;
   localparam int unsigned EXT_W = SIG_W + GRS_W;

   logic adv1, adv2, acc1;

   // Unpacked operands
   logic [EXP_W-1:0] e1, e2;
   logic [SIG_W-1:0] sig1, sig2;
   logic             swap_c;
   logic [EXP_W-1:0] diff_c;

   // Stage 1 state
   logic             s1_valid;
   logic             s1_swap;
   logic             s1_sign1;
   logic             s1_sign2;
   logic             s1_opcode;
   logic [EXP_W-1:0] s1_exp_large;
   logic [EXP_W-1:0] s1_diff;
   logic [SIG_W-1:0] s1_sig_large;
   logic [SIG_W-1:0] s1_sig_small;

   // Stage 2 shifter
   logic [EXT_W-1:0] ext;
   logic [EXT_W-1:0] shifted;
   logic [EXT_W-1:0] lost_mask;
   logic [EXT_W-1:0] small_c;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;
   assign acc1     = in_valid && adv1;

   always_comb begin
      e1   = op1[MAN_W +: EXP_W];
      e2   = op2[MAN_W +: EXP_W];
      sig1 = {1'b1, op1[MAN_W-1:0]};
      sig2 = {1'b1, op2[MAN_W-1:0]};
`ifdef FP_ALIGN_DENORM_EN
      // Subnormals sit at effective exponent 1 with no hidden bit.
      if (op1[MAN_W +: EXP_W] == '0) begin
         e1   = EXP_W'(1);
         sig1 = {1'b0, op1[MAN_W-1:0]};
      end
      if (op2[MAN_W +: EXP_W] == '0) begin
         e2   = EXP_W'(1);
         sig2 = {1'b0, op2[MAN_W-1:0]};
      end
`else
      if (op1[MAN_W +: EXP_W] == '0) begin
         sig1 = '0;
      end
      if (op2[MAN_W +: EXP_W] == '0) begin
         sig2 = '0;
      end
`endif
      swap_c = (e2 > e1) || ((e2 == e1) && (sig2 > sig1));
      diff_c = swap_c ? (e2 - e1) : (e1 - e2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s1_swap      <= 1'b0;
         s1_sign1     <= 1'b0;
         s1_sign2     <= 1'b0;
         s1_opcode    <= 1'b0;
         s1_exp_large <= '0;
         s1_diff      <= '0;
         s1_sig_large <= '0;
         s1_sig_small <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= in_valid;
         end
         if (acc1) begin
            s1_swap      <= swap_c;
            s1_sign1     <= op1[EXP_W+MAN_W];
            s1_sign2     <= op2[EXP_W+MAN_W];
            s1_opcode    <= opcode_in;
            s1_exp_large <= swap_c ? e2 : e1;
            s1_diff      <= diff_c;
            s1_sig_large <= swap_c ? sig2 : sig1;
            s1_sig_small <= swap_c ? sig1 : sig2;
         end
      end
   end

   always_comb begin
      ext       = {s1_sig_small, {GRS_W{1'b0}}};
      shifted   = ext >> s1_diff;
      lost_mask = ~({EXT_W{1'b1}} << s1_diff);
      if (32'(s1_diff) >= EXT_W) begin
         small_c = {{(EXT_W-1){1'b0}}, |s1_sig_small};
      end else begin
         small_c = shifted | EXT_W'(|(ext & lost_mask));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         swap       <= 1'b0;
         sign1_out  <= 1'b0;
         sign2_out  <= 1'b0;
         opcode_out <= 1'b0;
         exp_large  <= '0;
         mant_large <= '0;
         mant_small <= '0;
      end else begin
         if (adv2) begin
            out_valid <= s1_valid;
         end
         if (adv2 && s1_valid) begin
            swap       <= s1_swap;
            sign1_out  <= s1_sign1;
            sign2_out  <= s1_sign2;
            opcode_out <= s1_opcode;
            exp_large  <= s1_exp_large;
            mant_large <= {s1_sig_large, {GRS_W{1'b0}}};
            mant_small <= small_c;
         end
      end
   end

endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage: directed vectors, random traffic, back-pressure, reset.
module tb_fp_align_stage;

`ifdef FP_ALIGN_DENORM_EN
   localparam bit Denorm = 1'b1;
`else
   localparam bit Denorm = 1'b0;
`endif

   typedef struct packed {
      logic        swap;
      logic        sign1;
      logic        sign2;
      logic        opc;
      logic [7:0]  exp;
      logic [26:0] ml;
      logic [26:0] ms;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] op1, op2;
   logic        opcode_in;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic        swap, sign1_out, sign2_out, opcode_out;
   logic [7:0]  exp_large;
   logic [26:0] mant_large, mant_small;

   int compared   = 0;
   int mismatched = 0;
   int rdy_mode   = 0;
   exp_t sb[$];

   fp_align_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op1        (op1),
      .op2        (op2),
      .opcode_in  (opcode_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .swap       (swap),
      .sign1_out  (sign1_out),
      .sign2_out  (sign2_out),
      .opcode_out (opcode_out),
      .exp_large  (exp_large),
      .mant_large (mant_large),
      .mant_small (mant_small)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic sw, s1, s2, opc, input logic [7:0] e,
                               input logic [26:0] ml, ms);
      exp_t r;
      r.swap = sw; r.sign1 = s1; r.sign2 = s2; r.opc = opc;
      r.exp = e; r.ml = ml; r.ms = ms;
      return r;
   endfunction

   function automatic longint unsigned mag(input logic [31:0] x);
      if (!Denorm && x[30:23] == 8'd0) return 64'd0;
      return 64'(x[30:0]);
   endfunction

   function automatic int unsigned eff_exp(input logic [31:0] x);
      if (x[30:23] == 8'd0) return Denorm ? 1 : 0;
      return int'(x[30:23]);
   endfunction

   function automatic longint unsigned eff_sig(input logic [31:0] x);
      if (x[30:23] == 8'd0) return Denorm ? 64'(x[22:0]) : 64'd0;
      return 64'(x[22:0]) + 64'h80_0000;
   endfunction

   // Reference: IEEE bit patterns order by magnitude; alignment is division with remainder.
   function automatic exp_t model(input logic [31:0] a, b, input logic opc);
      logic [31:0] big, sml;
      logic sw;
      int unsigned eb, es, d;
      longint unsigned ext, p, q, r;
      sw  = mag(b) > mag(a);
      big = sw ? b : a;
      sml = sw ? a : b;
      eb  = eff_exp(big);
      es  = eff_exp(sml);
      d   = eb - es;
      ext = eff_sig(sml) * 8;
      if (d >= 27) begin
         q = (eff_sig(sml) != 0) ? 64'd1 : 64'd0;
      end else begin
         p = 64'd1 << d;
         q = ext / p;
         r = ext % p;
         if (r != 0) q = q | 64'd1;
      end
      return mk(sw, a[31], b[31], opc, 8'(eb), 27'(eff_sig(big) * 8), 27'(q));
   endfunction

   function automatic exp_t cur_out();
      return mk(swap, sign1_out, sign2_out, opcode_out, exp_large, mant_large, mant_small);
   endfunction

   task automatic send(input logic [31:0] a, b, input logic opc, input exp_t e);
      bit ok;
      int n;
      op1 = a; op2 = b; opcode_in = opc; in_valid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = in_ready;
         n++;
      end
      if (!ok) begin
         compared++; mismatched++;
         $display("FAIL accept_timeout op1=%h op2=%h in_ready stuck at 0", a, b);
      end else begin
         @(posedge clk);
         sb.push_back(e);
      end
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s actual=%b required=%b", name, act, req);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      compared++;
      if (cur_out() !== '0) begin
         mismatched++;
         $display("FAIL %s actual=%h required=0", name, cur_out());
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      end
      #1;
   endtask

   // out_ready driver
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops on each output transfer, checks output stability across stall cycles.
   initial begin
      exp_t prev, got, want;
      bit   stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            got = cur_out();
            if (stall) begin
               compared++;
               if (got !== prev || out_valid !== 1'b1) begin
                  mismatched++;
                  $display("FAIL stall_hold actual=%h v=%b required=%h v=1", got, out_valid, prev);
               end
            end
            if (out_valid && out_ready) begin
               compared++;
               if (sb.size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_output actual=%h required=none", got);
               end else begin
                  want = sb.pop_front();
                  if (got !== want) begin
                     mismatched++;
                     $display("FAIL result actual=%h required=%h", got, want);
                  end
               end
            end
            stall = out_valid && !out_ready;
            prev  = got;
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      logic [7:0]  ex;
      logic        opc;
      op1 = '0; op2 = '0; opcode_in = 1'b0; in_valid = 1'b0;
      rst_n = 1'b0;
      #23;
      check_bit("reset_out_valid", out_valid, 1'b0);
      check_bit("reset_in_ready", in_ready, 1'b1);
      check_zero_outputs("reset_outputs");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, mk(1, 0, 0, 0, 8'h80, 27'h400_0000, 27'h200_0000));
      send(32'h4040_0000, 32'h4040_0000, 1'b1, mk(0, 0, 0, 1, 8'h80, 27'h600_0000, 27'h600_0000));
      send(32'h4B80_0000, 32'h3F80_0001, 1'b0, mk(0, 0, 0, 0, 8'h97, 27'h400_0000, 27'h000_0005));
      send(32'h7F00_0000, 32'h3F80_0000, 1'b0, mk(0, 0, 0, 0, 8'hFE, 27'h400_0000, 27'h000_0001));
      send(32'hBF80_0000, 32'hC000_0000, 1'b1, mk(1, 1, 1, 1, 8'h80, 27'h400_0000, 27'h200_0000));
      send(32'h0000_0000, 32'h0000_0001, 1'b0,
           Denorm ? mk(1, 0, 0, 0, 8'h01, 27'h8, 27'h0) : mk(0, 0, 0, 0, 8'h00, 27'h0, 27'h0));
      send(32'h7F80_0000, 32'h7FC0_0000, 1'b0, model(32'h7F80_0000, 32'h7FC0_0000, 1'b0));
      idle();
      drain();

      // Back-pressure: stream four pairs into a stalled output.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               a = 32'h3F80_0000 + 32'(i << 20);
               b = 32'h3E00_0000 + 32'(i << 21);
               send(a, b, 1'(i), model(a, b, 1'(i)));
            end
            in_valid = 1'b0;
         end
         begin
            repeat (5) @(negedge clk);
            check_bit("bp_in_ready_low", in_ready, 1'b0);
            check_bit("bp_out_valid_high", out_valid, 1'b1);
            check_bit("bp_queue_depth", 1'(sb.size() == 2), 1'b1);
            repeat (3) @(negedge clk);
            rdy_mode = 0;
         end
      join
      drain();

      // Random traffic with random back-pressure and input bubbles.
      rdy_mode = 1;
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b[30:23] = a[30:23];
            1: begin ex = a[30:23] + 8'($urandom_range(0, 30)); b[30:23] = ex; end
            2: a[30:23] = 8'd0;
            3: b = a ^ 32'h8000_0000;
            4: begin a[30:23] = 8'd0; b[30:23] = 8'($urandom_range(0, 2)); end
            default: ;
         endcase
         opc = 1'($urandom_range(0, 1));
         send(a, b, opc, model(a, b, opc));
         if ($urandom_range(0, 3) == 0) idle();
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      drain();

      // Reset with both stages full.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send(32'h4000_0000, 32'h3F80_0000, 1'b1, model(32'h4000_0000, 32'h3F80_0000, 1'b1));
      send(32'h4100_0000, 32'h4040_0000, 1'b1, model(32'h4100_0000, 32'h4040_0000, 1'b1));
      in_valid = 1'b0;
      @(negedge clk);
      check_bit("full_before_reset", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check_zero_outputs("midrst_outputs");
      sb.delete();
      rdy_mode = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_bit("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, mk(1, 0, 0, 0, 8'h80, 27'h400_0000, 27'h200_0000));
      idle();
      drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Front-end alignment stage of the single-precision FP add/sub datapath.
- Unpacks two IEEE-754 operands, compares magnitudes, and produces the `swap` flag consumed by the sign logic and the swap/complement stage.
- Right-shifts the smaller significand with guard/round/sticky bits so the downstream adder receives aligned significands.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width (hidden bit added internally)
- GRS_W, 3, extension bits below LSB: guard, round, sticky; sticky is the LSB

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op1  input  1+EXP_W+MAN_W  operand 1: sign, exponent, fraction
- op2  input  1+EXP_W+MAN_W  operand 2
- opcode_in  input  1  0 = add, 1 = subtract; carried through
- in_valid  input  1  operands valid
- in_ready  output  1  stage accepts operands this cycle
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts the result
- swap  output  1  1 when |op2| > |op1|
- sign1_out, sign2_out  output  1 each  original operand signs, unswapped
- opcode_out  output  1  registered opcode
- exp_large  output  EXP_W  exponent of the larger operand
- mant_large  output  MAN_W+1+GRS_W  larger significand {hidden, frac, GRS=0}
- mant_small  output  MAN_W+1+GRS_W  smaller significand, shifted right, sticky ORed into LSB

Behaviour:
- Reset (asynchronous, rst_n=0): all internal valids and out_valid = 0; every data output register = 0.
- in_ready is combinational: `adv2 = !out_valid || out_ready`; `adv1 = !s1_valid || adv2`; `in_ready = adv1`.
- Transfer occurs on `in_valid && in_ready` and on `out_valid && out_ready`.
- Stage 1, registered on input transfer:
  - Unpack the hidden bit: 1 if exponent != 0.
  - swap = (e2 > e1) || (e2 == e1 && f2 > f1).
  - Equal magnitudes give swap = 0.
  - Latch signs, opcode, exp_large, both significands in swapped order, and diff = e_large - e_small (unsigned, EXP_W bits).
- Stage 2, registered when adv2 && s1_valid:
  - `mant_large = {sig_large, GRS_W'0}`.
  - `ext = {sig_small, GRS_W'0}`.
  - If diff >= MAN_W+1+GRS_W: `mant_small = {all zero, sticky = |sig_small}`.
  - Otherwise: `mant_small = ext >> diff`, with LSB ORed with the OR of all shifted-out bits.
  - out_valid is set.
  - If adv2 && !s1_valid, out_valid clears.
- Latency: 2 cycles from input transfer to out_valid when not stalled.
- Throughput: 1 result per cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable.
  - Stage 1 fills, if empty, and then in_ready drops.
  - No data is dropped or duplicated.
- Simultaneous events: an output transfer and a new stage-1 advance in the same cycle are legal (full-rate pipelining).
- Special values: NaN/Inf operands are aligned as ordinary numbers (exponent all-ones); detection is downstream's responsibility.
- Reset mid-operation: in-flight data is discarded; in_ready = 1 after reset release.

Optional Feature:
- Macro: FP_ALIGN_DENORM_EN.
- Defined: exponent-0 operands are subnormal.
  - Hidden bit = 0.
  - Effective exponent = 1 for the compare and the diff.
  - exp_large reports 1 when both operands are subnormal.
- Undefined: exponent-0 operands flush to zero.
  - Significand forced to 0 before comparison.
  - Exponent used as 0.

Test Plan:
- op1=0x3F800000 (1.0), op2=0x40000000 (2.0), add -> 2 cycles later:
  - swap=1, exp_large=0x80
  - mant_large=0x4000000, mant_small=0x2000000
- op1=op2=0x40400000 (3.0), subtract -> swap=0, exp_large=0x80, mant_large=mant_small=0x6000000, opcode_out=1.
- op1=0x4B800000, op2=0x3F800001 (diff 24) -> swap=0, mant_small=0x0000005 (shifted value 4 plus sticky).
- op1=0x7F000000, op2=0x3F800000 (diff 127 >= 27) -> mant_small=0x0000001.
- Back-pressure: stream 4 operand pairs at full rate, hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0 after 1 extra accept, all 4 results emerge in order with none lost.
- Assert rst_n=0 with both stages full -> out_valid=0 and outputs=0 immediately; after release in_ready=1.
- op2=0x00000001, op1=0 with macro defined -> swap=1, mant_large=0x0000008, exp_large=1.
- Same operands with macro undefined -> swap=0, both significands 0.
